fc_forward: RTL and testbench

- Forward-pass fully-connected layer: 128 activations in, 10 logits out, signed Q8.8 fixed point.
- Produces the outputs whose errors drive the weight-update generator. Uses the same row-major weight layout [i][j] with address i*N_OUT+j.
- Buffers one input frame and computes outputs sequentially with one MAC over an external weight memory.
- Streams the logits out over a valid/ready handshake.

---
 rtl/fc_pkg.sv | 33 +++
 rtl/fc_forward_if.sv | 27 ++
 rtl/fc_mac_sat.sv | 31 +++
 rtl/fc_forward.sv | 141 ++++++++++++++
 tb/tb_fc_forward.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fc_pkg.sv
// Shared sizes, FSM states and the Q8.8 output saturation helper for the
// forward fully-connected layer.
package fc_pkg;
  localparam int N_IN  = 128;
  localparam int N_OUT = 10;
  localparam int DW    = 16;
  localparam int FRAC  = 8;
  localparam int ACC_W = 40;
  localparam int AW    = 11;
  localparam int IDX_W = 4;

  typedef enum logic [1:0] {
    LOAD,
    COMPUTE,
    OUTPUT
  } state_e;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (DW - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(64'sd1 <<< (DW - 1)));

  // Arithmetic shift floors toward -inf; the result is then clamped to the DW-bit signed range
  function automatic logic [DW-1:0] sat_q(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] shifted;
    shifted = acc >>> FRAC;
    if (shifted > SAT_MAX) begin
      sat_q = {1'b0, {(DW - 1){1'b1}}};
    end else if (shifted < SAT_MIN) begin
      sat_q = {1'b1, {(DW - 1){1'b0}}};
    end else begin
      sat_q = shifted[DW-1:0];
    end
  endfunction
endpackage

// File: rtl/fc_forward_if.sv
// Activation input stream, weight-memory read port and logit output stream
// of the forward layer, bundled as one interface.
interface fc_forward_if;
  import fc_pkg::*;

  logic [DW-1:0]    in_data;
  logic             in_valid;
  logic             in_ready;
  logic             w_rd_en;
  logic [AW-1:0]    w_addr;
  logic [DW-1:0]    w_rdata;
  logic [DW-1:0]    out_data;
  logic [IDX_W-1:0] out_idx;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  modport master (
    output in_data, in_valid, w_rdata, out_ready,
    input  in_ready, w_rd_en, w_addr, out_data, out_idx, out_valid, out_last
  );

  modport slave (
    input  in_data, in_valid, w_rdata, out_ready,
    output in_ready, w_rd_en, w_addr, out_data, out_idx, out_valid, out_last
  );
endinterface

// File: rtl/fc_mac_sat.sv
// Registered multiply-accumulate: clr_i restarts the sum at the current
// product, y_o is the running total reduced to saturated Q8.8.
module fc_mac_sat
  import fc_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 clr_i,
  input  logic signed [DW-1:0] a_i,
  input  logic signed [DW-1:0] b_i,
  output logic [DW-1:0]        y_o
);
  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] prodExt;
  logic signed [ACC_W-1:0] base;
  logic signed [ACC_W-1:0] acc_q;

  assign prod    = a_i * b_i;
  assign prodExt = {{(ACC_W - 2 * DW){prod[2*DW-1]}}, prod};
  assign base    = clr_i ? '0 : acc_q;
  assign y_o     = sat_q(acc_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= base + prodExt;
    end
  end
endmodule

// File: rtl/fc_forward.sv
// Forward fully-connected layer: buffers one activation frame, computes each
// logit with a single MAC over external weight memory, then streams logits out.
module fc_forward
  import fc_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  fc_forward_if.slave bus,
  output logic        busy_o
);
  localparam int LCW = $clog2(N_IN);
  localparam int ICW = $clog2(N_IN + 1);
  localparam logic [LCW-1:0]   LOAD_LAST  = LCW'(N_IN - 1);
  localparam logic [ICW-1:0]   DRAIN_I    = ICW'(N_IN);
  localparam logic [IDX_W-1:0] LAST_J     = IDX_W'(N_OUT - 1);
  localparam logic [AW-1:0]    ROW_STRIDE = AW'(N_OUT);

  state_e           state_q, state_d;
  logic [LCW-1:0]   loadCnt_q, loadCnt_d;
  logic [ICW-1:0]   iCnt_q, iCnt_d;
  logic [IDX_W-1:0] jCnt_q, jCnt_d;
  logic [IDX_W-1:0] oCnt_q, oCnt_d;
  logic [AW-1:0]    addr_q, issueAddr, wAddr;
  logic             macEn_q, macClr_q, store_q;
  logic [IDX_W-1:0] storeIdx_q;
  logic [DW-1:0]    xSel_q;
  logic [DW-1:0]    xBuf_q [N_IN];
  logic [DW-1:0]    result_q [N_OUT];
  logic [DW-1:0]    macY;
  logic             inReady, outValid, inFire, outFire, issue, drain;

  assign issue     = (state_q == COMPUTE) && (iCnt_q != DRAIN_I);
  assign drain     = (state_q == COMPUTE) && (iCnt_q == DRAIN_I);
  assign issueAddr = AW'(iCnt_q) * ROW_STRIDE + AW'(jCnt_q);
  assign wAddr     = issue ? issueAddr : addr_q;
  assign inReady   = (state_q == LOAD) && !rst_i;
  assign outValid  = (state_q == OUTPUT);
  assign inFire    = bus.in_valid && inReady;
  assign outFire   = outValid && bus.out_ready;

  assign bus.in_ready  = inReady;
  assign bus.w_rd_en   = issue;
  assign bus.w_addr    = wAddr;
  assign bus.out_valid = outValid;
  assign bus.out_idx   = oCnt_q;
  assign bus.out_last  = outValid && (oCnt_q == LAST_J);
  assign bus.out_data  = outValid ? result_q[oCnt_q] : '0;
  assign busy_o        = (state_q != LOAD);

  // Each logit takes N_IN issue cycles plus one drain cycle for the last read to land
  always_comb begin
    state_d   = state_q;
    loadCnt_d = loadCnt_q;
    iCnt_d    = iCnt_q;
    jCnt_d    = jCnt_q;
    oCnt_d    = oCnt_q;
    unique case (state_q)
      LOAD: begin
        if (inFire) begin
          if (loadCnt_q == LOAD_LAST) begin
            loadCnt_d = '0;
            state_d   = COMPUTE;
          end else begin
            loadCnt_d = loadCnt_q + LCW'(1);
          end
        end
      end
      COMPUTE: begin
        if (drain) begin
          iCnt_d = '0;
          if (jCnt_q == LAST_J) begin
            jCnt_d  = '0;
            state_d = OUTPUT;
          end else begin
            jCnt_d = jCnt_q + IDX_W'(1);
          end
        end else begin
          iCnt_d = iCnt_q + ICW'(1);
        end
      end
      OUTPUT: begin
        if (outFire) begin
          if (oCnt_q == LAST_J) begin
            oCnt_d  = '0;
            state_d = LOAD;
          end else begin
            oCnt_d = oCnt_q + IDX_W'(1);
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= LOAD;
      loadCnt_q  <= '0;
      iCnt_q     <= '0;
      jCnt_q     <= '0;
      oCnt_q     <= '0;
      addr_q     <= '0;
      macEn_q    <= 1'b0;
      macClr_q   <= 1'b0;
      store_q    <= 1'b0;
      storeIdx_q <= '0;
    end else begin
      state_q    <= state_d;
      loadCnt_q  <= loadCnt_d;
      iCnt_q     <= iCnt_d;
      jCnt_q     <= jCnt_d;
      oCnt_q     <= oCnt_d;
      addr_q     <= wAddr;
      macEn_q    <= issue;
      macClr_q   <= issue && (iCnt_q == '0);
      store_q    <= drain;
      storeIdx_q <= jCnt_q;
    end
  end

  // Storage only: a reset discards the frame through the control state above
  always_ff @(posedge clk_i) begin
    if (inFire) begin
      xBuf_q[loadCnt_q] <= bus.in_data;
    end
    xSel_q <= xBuf_q[iCnt_q[LCW-1:0]];
    if (store_q) begin
      result_q[storeIdx_q] <= macY;
    end
  end

  fc_mac_sat u_mac (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (macEn_q),
    .clr_i (macClr_q),
    .a_i   (xSel_q),
    .b_i   (bus.w_rdata),
    .y_o   (macY)
  );
endmodule

// File: tb/tb_fc_forward.sv
// Self-checking bench for fc_forward: directed vector table, randomized frames
// against an arithmetic reference model, stall and mid-frame reset sequences.
module tb_fc_forward;

  typedef struct {
    string       name;
    int          xIdx;
    logic [15:0] xVal;
    logic [15:0] xFill;
    logic [15:0] wVal;
    logic [15:0] wFill;
    bit          wRamp;
    logic [15:0] expY0;
    logic [15:0] expYStep;
    int          stallIdx;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        busy;
  int          cyc = 0;
  int          nChecks = 0;
  int          nFails = 0;
  int          lastInCycle = 0;
  int          strayRd = 0;
  logic [15:0] xVec [128];
  logic [15:0] wMem [2048];
  logic [15:0] yExp [10];
  logic [10:0] addrLog [$];
  vec_t        vecs [6];

  fc_forward_if bus ();

  fc_forward dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus    (bus),
    .busy_o (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Weight memory: one-cycle read latency, plus a log of every issued address
  always @(posedge clk) begin
    if (bus.w_rd_en) begin
      bus.w_rdata <= wMem[bus.w_addr];
      addrLog.push_back(bus.w_addr);
      if (!busy) strayRd <= strayRd + 1;
    end
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string what, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", what, act, exp);
    end
  endtask

  function automatic vec_t mkVec(string n, int xi, logic [15:0] xv, logic [15:0] xf,
                                 logic [15:0] wv, logic [15:0] wf, bit ramp,
                                 logic [15:0] e0, logic [15:0] es, int st);
    vec_t v;
    v.name = n; v.xIdx = xi; v.xVal = xv; v.xFill = xf; v.wVal = wv; v.wFill = wf;
    v.wRamp = ramp; v.expY0 = e0; v.expYStep = es; v.stallIdx = st;
    return v;
  endfunction

  // Reference: exact integer dot product, floor divide by 256, clamp to int16
  function automatic logic [15:0] refY(int j);
    longint sum = 0;
    longint q;
    for (int i = 0; i < 128; i++)
      sum += longint'($signed(xVec[i])) * longint'($signed(wMem[i*10 + j]));
    q = sum >>> 8;
    if (q > 32767) return 16'h7FFF;
    if (q < -32768) return 16'h8000;
    return q[15:0];
  endfunction

  task automatic loadVector(input vec_t v);
    for (int i = 0; i < 128; i++) xVec[i] = (i == v.xIdx) ? v.xVal : v.xFill;
    for (int i = 0; i < 128; i++)
      for (int j = 0; j < 10; j++)
        wMem[i*10 + j] = (i == v.xIdx) ? (v.wRamp ? 16'(j * int'(v.wVal)) : v.wVal) : v.wFill;
    for (int j = 0; j < 10; j++) yExp[j] = v.expY0 + 16'(j) * v.expYStep;
  endtask

  task automatic randomFrame(input int mode);
    for (int i = 0; i < 128; i++)
      xVec[i] = (mode == 0) ? 16'($urandom) : 16'(int'($urandom_range(0, 1023)) - 512);
    for (int k = 0; k < 1280; k++)
      wMem[k] = (mode == 2) ? 16'(int'($urandom_range(0, 2047)) - 1024) : 16'($urandom);
    for (int j = 0; j < 10; j++) yExp[j] = refY(j);
  endtask

  task automatic applyStimulus(input int nBeats, input bit gaps);
    int i = 0;
    int guard = 0;
    while (i < nBeats && guard < 4000) begin
      @(negedge clk);
      guard++;
      if (gaps && $urandom_range(3) == 0) begin
        bus.in_valid = 1'b0;
      end else begin
        bus.in_valid = 1'b1;
        bus.in_data  = xVec[i];
        if (bus.in_ready) begin
          lastInCycle = cyc;
          i++;
        end
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    if (i < nBeats) checkOutput("in_ready timeout beats accepted", i, nBeats);
  endtask

  task automatic collectFrame(input int stallIdx, input int stallLen, input bit junkIn, input bit randStall);
    int guard = 0;
    int extra;
    while (bus.out_valid !== 1'b1 && guard < 3000) begin
      if (junkIn) begin
        bus.in_valid = 1'b1;
        bus.in_data  = 16'($urandom);
      end
      @(negedge clk);
      guard++;
    end
    bus.in_valid = 1'b0;
    if (guard >= 3000) begin
      checkOutput("out_valid timeout", bus.out_valid, 1);
      return;
    end
    checkOutput("first out_valid latency", cyc - lastInCycle, 1291);
    checkOutput("busy during OUTPUT", busy, 1);
    for (int j = 0; j < 10; j++) begin
      checkOutput($sformatf("out_valid j=%0d", j), bus.out_valid, 1);
      checkOutput($sformatf("out_idx j=%0d", j), bus.out_idx, j);
      checkOutput($sformatf("out_data j=%0d", j), bus.out_data, yExp[j]);
      checkOutput($sformatf("out_last j=%0d", j), bus.out_last, (j == 9));
      checkOutput($sformatf("in_ready low j=%0d", j), bus.in_ready, 0);
      extra = (j == stallIdx) ? stallLen : (randStall ? int'($urandom_range(0, 2)) : 0);
      for (int s = 0; s < extra; s++) begin
        @(negedge clk);
        checkOutput($sformatf("stall out_valid j=%0d", j), bus.out_valid, 1);
        checkOutput($sformatf("stall out_idx j=%0d", j), bus.out_idx, j);
        checkOutput($sformatf("stall out_data j=%0d", j), bus.out_data, yExp[j]);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
    end
    checkOutput("in_ready after last beat", bus.in_ready, 1);
    checkOutput("out_valid after last beat", bus.out_valid, 0);
    checkOutput("busy after last beat", busy, 0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " in_ready"}, bus.in_ready, 1);
    checkOutput({tag, " w_rd_en"}, bus.w_rd_en, 0);
    checkOutput({tag, " w_addr"}, bus.w_addr, 0);
    checkOutput({tag, " out_valid"}, bus.out_valid, 0);
    checkOutput({tag, " out_last"}, bus.out_last, 0);
    checkOutput({tag, " out_data"}, bus.out_data, 0);
    checkOutput({tag, " out_idx"}, bus.out_idx, 0);
    checkOutput({tag, " busy"}, busy, 0);
  endtask

  initial begin
    int bad;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    vecs[0] = mkVec("posSat",      0, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 1'b0, 16'h7FFF, 16'h0000, -1);
    vecs[1] = mkVec("negExact",    0, 16'h0100, 16'h0100, 16'hFF00, 16'hFF00, 1'b0, 16'h8000, 16'h0000, -1);
    vecs[2] = mkVec("halfLsbPos",  0, 16'h0001, 16'h0000, 16'h0080, 16'h5555, 1'b0, 16'h0000, 16'h0000, -1);
    vecs[3] = mkVec("halfLsbNeg",  0, 16'h0001, 16'h0000, 16'hFF80, 16'h5555, 1'b0, 16'hFFFF, 16'h0000, -1);
    vecs[4] = mkVec("rampRow5",    5, 16'h0100, 16'h0000, 16'h0100, 16'h1234, 1'b1, 16'h0000, 16'h0100,  3);
    vecs[5] = mkVec("smallSum",    0, 16'h0001, 16'h0001, 16'h0100, 16'h0100, 1'b0, 16'h0080, 16'h0000, -1);

    repeat (3) @(negedge clk);
    checkOutput("in_ready during rst", bus.in_ready, 0);
    rst = 1'b0;
    #1;
    checkResetValues("reset");

    for (int k = 0; k < 6; k++) begin
      loadVector(vecs[k]);
      addrLog.delete();
      applyStimulus(128, (k % 2) == 1);
      collectFrame(vecs[k].stallIdx, 20, k == 2, 1'b0);
      bad = 0;
      for (int i = 0; i < 128 && i < addrLog.size(); i++)
        if (addrLog[i] != 11'(i * 10)) bad++;
      checkOutput({vecs[k].name, " w_addr sequence j=0"}, bad, 0);
      checkOutput({vecs[k].name, " w_rd_en count"}, addrLog.size(), 1280);
    end

    // Reset in the middle of COMPUTE, then a clean frame
    loadVector(vecs[4]);
    applyStimulus(128, 1'b0);
    while (cyc < lastInCycle + 500) @(negedge clk);
    checkOutput("w_rd_en before mid-COMPUTE rst", bus.w_rd_en, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkResetValues("after mid-COMPUTE rst");
    randomFrame(2);
    applyStimulus(128, 1'b1);
    collectFrame(-1, 0, 1'b0, 1'b1);

    // Reset in the middle of LOAD; the next frame must start at x[0]
    randomFrame(1);
    applyStimulus(50, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("in_ready after mid-LOAD rst", bus.in_ready, 1);
    checkOutput("busy after mid-LOAD rst", busy, 0);
    randomFrame(2);
    applyStimulus(128, 1'b1);
    collectFrame(-1, 0, 1'b1, 1'b1);

    randomFrame(1);
    applyStimulus(128, 1'b1);
    collectFrame(7, 5, 1'b0, 1'b1);

    randomFrame(0);
    applyStimulus(128, 1'b0);
    collectFrame(-1, 0, 1'b0, 1'b1);

    checkOutput("w_rd_en while not busy", strayRd, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
